// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the display pixel packer:
//   - FSM state encoding (3-bit localparam constants)
//   - default frame size and flush length
//   - byte width of a packed page byte
//   - pack_bit(): writes one pixel into a given bit of a page byte
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam int BYTE_W           = 8;
    localparam int FRAME_BYTES_DEF  = 1024;   // 128 columns x 8 pages
    localparam int FLUSH_CYCLES_DEF = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Returns 'data' with bit 'idx' replaced by 'val'. Page bytes are built
    // LSB first, so the first pixel of a column lands in bit 0.
    function automatic logic [BYTE_W-1:0] pack_bit(
        input logic [BYTE_W-1:0] data,
        input logic [2:0]        idx,
        input logic              val
    );
        logic [BYTE_W-1:0] res;
        res      = data;
        res[idx] = val;
        return res;
    endfunction

endpackage

// File: rtl/disp_px_packer.sv
// ---------------------------------------------------------------------------
// disp_px_packer
// Collects a serial stream of 1-bit pixels from the static-pixel decoder and
// packs them, LSB first, into 8-bit page bytes for the display writer. A
// frame is FRAME_BYTES bytes; the last byte is flagged with byte_last.
//
// Parameters:
//   FRAME_BYTES  - bytes per display frame
//   FLUSH_CYCLES - cycles 'flush' is held high at frame start
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   frame_start in   single-cycle pulse; starts or restarts (aborts) a frame
//   flush       out  flush request to the upstream decoder
//   px_ready    out  ready to accept one pixel (FILL only)
//   px_valid    in   upstream pixel valid
//   px_in       in   upstream pixel value
//   byte_valid  out  packed byte valid (OUT only)
//   byte_data   out  packed page byte, bit k = k-th pixel
//   byte_last   out  qualifies the final byte of the frame
//   byte_ready  in   downstream accepts the byte
//   busy        out  high in any state other than IDLE
//
// Build option:
//   DISP_PX_INVERT_EN - when defined, every accepted pixel is inverted before
//                       packing (inverse video). Interface/timing unchanged.
// ---------------------------------------------------------------------------
module disp_px_packer
    import disp_pkg::*;
#(
    parameter int FRAME_BYTES  = FRAME_BYTES_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              flush,
    output logic              px_ready,
    input  logic              px_valid,
    input  logic              px_in,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_last,
    input  logic              byte_ready,
    output logic              busy
);

    // Counter widths; clamp to 1 bit so degenerate parameters still elaborate.
    localparam int BCW = (FRAME_BYTES  > 1) ? $clog2(FRAME_BYTES)  : 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [BCW-1:0] LAST_BYTE  = BCW'(FRAME_BYTES - 1);
    localparam logic [FCW-1:0] LAST_FLUSH = FCW'(FLUSH_CYCLES - 1);

    logic [2:0]        state;
    logic [FCW-1:0]    flush_cnt;
    logic [2:0]        bit_cnt;
    logic [BCW-1:0]    byte_cnt;
    logic [BYTE_W-1:0] byte_q;
    logic              px_bit;
    logic              at_last_byte;

`ifdef DISP_PX_INVERT_EN
    assign px_bit = ~px_in;
`else
    assign px_bit = px_in;
`endif

    assign at_last_byte = (byte_cnt == LAST_BYTE);

    // All handshake outputs are decoded from registered state, so they change
    // only on clock edges and drop together on abort or reset.
    assign flush      = (state == ST_FLUSH);
    assign px_ready   = (state == ST_FILL);
    assign byte_valid = (state == ST_OUT);
    assign byte_last  = (state == ST_OUT) && at_last_byte;
    assign busy       = (state != ST_IDLE);
    assign byte_data  = byte_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_q    <= '0;
        end else if (frame_start) begin
            // Start from IDLE, restart of FLUSH and mid-frame abort are the
            // same operation. It wins over a simultaneous byte handshake, so
            // a byte accepted on this edge is treated as not delivered.
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end

                ST_FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state <= ST_FILL;
                    end else begin
                        flush_cnt <= flush_cnt + FCW'(1);
                    end
                end

                ST_FILL: begin
                    // px_ready is high throughout FILL, so px_valid alone
                    // marks a transfer. bit_cnt wraps 7 -> 0 on its own.
                    if (px_valid) begin
                        byte_q  <= pack_bit(byte_q, bit_cnt, px_bit);
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_OUT;
                        end
                    end
                end

                ST_OUT: begin
                    // byte_q is untouched here, keeping data stable under
                    // backpressure.
                    if (byte_ready) begin
                        if (at_last_byte) begin
                            // Hold at the final index instead of wrapping.
                            state <= ST_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                            state    <= ST_FILL;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_px_packer.sv
// ---------------------------------------------------------------------------
// tb_disp_px_packer
// Directed bench for disp_px_packer with default parameters
// (FRAME_BYTES=1024, FLUSH_CYCLES=3). Expected bytes are written for
// non-inverted pixels and XORed with INV when DISP_PX_INVERT_EN is defined.
// ---------------------------------------------------------------------------
module tb_disp_px_packer;

`ifdef DISP_PX_INVERT_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       flush;
    logic       px_ready;
    logic       px_valid;
    logic       px_in;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disp_px_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .flush      (flush),
        .px_ready   (px_ready),
        .px_valid   (px_valid),
        .px_in      (px_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    logic seq_8d [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic seq_aa [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic seq_02 [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        px_valid    = 1'b0;
        px_in       = 1'b0;
        byte_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_flush",      flush,      0);
        check("rst_px_ready",   px_ready,   0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_last",  byte_last,  0);
        check("rst_busy",       busy,       0);
        check("rst_byte_data",  byte_data,  8'h00);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Frame start: flush exactly 3 cycles, then ready for pixels
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_hi",       flush,    1);
            check("flush_px_ready", px_ready, 0);
            check("flush_busy",     busy,     1);
            tick();
        end
        check("flush_lo",    flush,    0);
        check("fill_ready",  px_ready, 1);

        // Pixels 1,0,1,1,0,0,0,1 -> 8'h8D, valid for one cycle
        byte_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("8d_no_early_valid", byte_valid, 0);
            px_valid = 1'b1;
            px_in    = seq_8d[k];
            tick();
        end
        px_valid = 1'b0;
        check("8d_valid",    byte_valid, 1);
        check("8d_data",     byte_data,  8'h8D ^ INV);
        check("8d_px_ready", px_ready,   0);
        check("8d_last",     byte_last,  0);
        tick();
        check("8d_valid_1cyc", byte_valid, 0);
        check("8d_back_fill",  px_ready,   1);

        // Backpressure: byte_ready low 5 cycles, pixels offered but ignored
        byte_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            px_valid = 1'b1;
            px_in    = seq_aa[k];
            tick();
        end
        px_in = 1'b1;
        check("bp_valid", byte_valid, 1);
        check("bp_data0", byte_data,  8'hAA ^ INV);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", byte_valid, 1);
            check("bp_hold_data",  byte_data,  8'hAA ^ INV);
            check("bp_px_ready",   px_ready,   0);
        end
        px_valid   = 1'b0;
        byte_ready = 1'b1;
        tick();
        check("bp_released", byte_valid, 0);

        // Abort after 3 pixels: no byte, FLUSH again, fresh byte afterwards
        for (int k = 0; k < 3; k++) begin
            px_valid = 1'b1;
            px_in    = 1'b1;
            tick();
        end
        px_valid    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort_flush",      flush,      1);
        check("abort_no_byte",    byte_valid, 0);
        check("abort_px_ready",   px_ready,   0);
        tick();
        tick();
        tick();
        check("abort_refill", px_ready, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("abort_no_early_valid", byte_valid, 0);
            px_valid = 1'b1;
            px_in    = seq_02[k];
            tick();
        end
        px_valid = 1'b0;
        check("abort_fresh_valid", byte_valid, 1);
        check("abort_fresh_data",  byte_data,  8'h02 ^ INV);

        // Abort in OUT together with a handshake: abort wins
        frame_start = 1'b1;
        byte_ready  = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort_out_valid", byte_valid, 0);
        check("abort_out_flush", flush,      1);
        tick();
        tick();
        tick();
        check("frame_fill", px_ready, 1);

        // Full frame of all-1 pixels: 1024 bytes, last flag only on byte 1023
        byte_ready = 1'b0;
        px_in      = 1'b1;
        for (int b = 0; b < 1024; b++) begin
            px_valid = 1'b1;
            for (int k = 0; k < 8; k++) tick();
            px_valid = 1'b0;
            check("frame_valid", byte_valid, 1);
            check("frame_data",  byte_data,  8'hFF ^ INV);
            check("frame_last",  byte_last,  (b == 1023) ? 1 : 0);
            byte_ready = 1'b1;
            tick();
            byte_ready = 1'b0;
        end
        check("done_busy",  busy,       1);
        check("done_valid", byte_valid, 0);
        tick();
        check("end_busy",   busy,       0);

        // Pixels offered in IDLE are ignored
        px_valid = 1'b1;
        px_in    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_px_ready", px_ready,   0);
            check("idle_valid",    byte_valid, 0);
        end

        // New frame with px_valid already high through FLUSH; all-0 pixels
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        tick();
        check("zero_fill", px_ready, 1);
        px_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("zero_no_early_valid", byte_valid, 0);
            tick();
        end
        px_valid = 1'b0;
        check("zero_valid", byte_valid, 1);
        check("zero_data",  byte_data,  8'h00 ^ INV);
        byte_ready = 1'b1;
        tick();

        // Reset mid-frame discards the partial byte
        px_valid = 1'b1;
        px_in    = 1'b1;
        tick();
        tick();
        tick();
        px_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("midrst_busy",  busy,       0);
        check("midrst_data",  byte_data,  8'h00);
        check("midrst_ready", px_ready,   0);
        check("midrst_flush", flush,      0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle",  busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
